// File: rtl/pam4_pkg.sv
// ============================================================================
// Module      : pam4_pkg
// Description : Shared PAM4 Gray codes and fixed-point level definitions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pam4_pkg;

    typedef enum logic [1:0] {
        GRAY_00 = 2'b00,
        GRAY_01 = 2'b01,
        GRAY_11 = 2'b11,
        GRAY_10 = 2'b10
    } gray_sym_t;

    localparam logic [8:0] C_PRBS9_SEED = 9'h1FF;

    // Levels are +-0.25 / +-0.75 full scale; NBF fractional bits give 1.0 = 1<<NBF.
    function automatic int lvl_neg_075(input int nbf);
        return -(3 << (nbf - 2));
    endfunction

    function automatic int lvl_neg_025(input int nbf);
        return -(1 << (nbf - 2));
    endfunction

    function automatic int lvl_pos_025(input int nbf);
        return (1 << (nbf - 2));
    endfunction

    function automatic int lvl_pos_075(input int nbf);
        return (3 << (nbf - 2));
    endfunction

    function automatic int gray_to_level(input logic [1:0] sym, input int nbf);
        int lvl;
        case (sym)
            GRAY_00: lvl = lvl_neg_075(nbf);
            GRAY_01: lvl = lvl_neg_025(nbf);
            GRAY_11: lvl = lvl_pos_025(nbf);
            default: lvl = lvl_pos_075(nbf);
        endcase
        return lvl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prbs9_gen.sv
// ============================================================================
// Module      : prbs9_gen
// Description : PRBS9 (x^9+x^5+1) source, two bits per step, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs9_gen #(
    parameter logic [8:0] SEED = 9'h1FF
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_step,
    output logic [1:0] o_bits
);

    logic [8:0] r_state;
    logic [8:0] w_state_1;
    logic [8:0] w_state_2;
    logic       w_bit_1;
    logic       w_bit_2;

    // Two chained single-bit shifts; o_bits reflects the pair the next step consumes.
    always_comb begin
        w_bit_1   = r_state[8] ^ r_state[4];
        w_state_1 = {r_state[7:0], w_bit_1};
        w_bit_2   = w_state_1[8] ^ w_state_1[4];
        w_state_2 = {w_state_1[7:0], w_bit_2};
    end

    assign o_bits = {w_bit_1, w_bit_2};

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= SEED;
        end else if (i_step) begin
            r_state <= w_state_2;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pam4_tx_mapper.sv
// ============================================================================
// Module      : pam4_tx_mapper
// Description : Gray-coded PAM4 symbol mapper with zero-stuffing to OS samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pam4_tx_mapper
    import pam4_pkg::*;
#(
    parameter int NB  = 8,
    parameter int NBF = 7,
    parameter int OS  = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_prbs_en,
    input  logic [1:0]           i_bits,
    output logic                 o_req,
    output logic signed [NB-1:0] o_sample,
    output logic signed [NB-1:0] o_symbol,
    output logic [1:0]           o_gray_level,
    output logic                 o_sym_valid
);

    localparam int            C_PW         = (OS > 1) ? $clog2(OS) : 1;
    localparam logic [C_PW-1:0] C_LAST_PHASE = C_PW'(OS - 1);

    logic [C_PW-1:0]     r_phase;
    logic                w_fetch;
    logic [1:0]          w_prbs_bits;
    logic [1:0]          w_bits;
    logic signed [NB-1:0] w_level;

    assign w_fetch = i_enable && (r_phase == '0);
    assign o_req   = w_fetch && !i_prbs_en;
    assign w_bits  = i_prbs_en ? w_prbs_bits : i_bits;
    assign w_level = NB'(gray_to_level(w_bits, NBF));

    prbs9_gen #(
        .SEED (C_PRBS9_SEED)
    ) u_prbs9 (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_step  (w_fetch && i_prbs_en),
        .o_bits  (w_prbs_bits)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_phase      <= '0;
            o_sample     <= '0;
            o_symbol     <= '0;
            o_gray_level <= '0;
            o_sym_valid  <= 1'b0;
        end else if (i_enable) begin
            r_phase <= (r_phase == C_LAST_PHASE) ? '0 : r_phase + 1'b1;
            if (r_phase == '0) begin
                o_sample     <= w_level;
                o_symbol     <= w_level;
                o_gray_level <= w_bits;
                o_sym_valid  <= 1'b1;
            end else begin
                o_sample    <= '0;
                o_sym_valid <= 1'b0;
            end
        end else begin
            // Frozen: sample/symbol/phase hold, only the strobe is dropped.
            o_sym_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pam4_tx_mapper.sv
// ============================================================================
// Module      : tb_pam4_tx_mapper
// Description : Randomized + directed bench for pam4_tx_mapper (OS=4 and OS=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pam4_tx_mapper;

    localparam int NB  = 8;
    localparam int NBF = 7;
    localparam int NPB = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic       prbs;
    logic [1:0] bits;

    logic                 req_a, val_a, req_b, val_b;
    logic signed [NB-1:0] smp_a, sym_a, smp_b, sym_b;
    logic [1:0]           gray_a, gray_b;

    pam4_tx_mapper #(.NB(NB), .NBF(NBF), .OS(4)) dut4 (
        .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_prbs_en(prbs), .i_bits(bits),
        .o_req(req_a), .o_sample(smp_a), .o_symbol(sym_a), .o_gray_level(gray_a),
        .o_sym_valid(val_a)
    );

    pam4_tx_mapper #(.NB(NB), .NBF(NBF), .OS(1)) dut1 (
        .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_prbs_en(prbs), .i_bits(bits),
        .o_req(req_b), .o_sample(smp_b), .o_symbol(sym_b), .o_gray_level(gray_b),
        .o_sym_valid(val_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // PRBS9 bit stream from its recurrence: b[k] = b[k-9] ^ b[k-5], prior bits all 1.
    bit h[0:NPB+8];

    int m_ph[2], m_ptr[2], m_smp[2], m_sym[2], m_gray[2], m_val[2];
    int osv[2];
    int q_sym[$];
    logic s_req;

    function automatic int lvl(input logic [1:0] b);
        int unit;
        unit = 1 << (NBF - 2);
        case (b)
            2'b00:   return -3 * unit;
            2'b01:   return -1 * unit;
            2'b11:   return  1 * unit;
            default: return  3 * unit;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_ptr[i] = 0; m_smp[i] = 0;
            m_sym[i] = 0; m_gray[i] = 0; m_val[i] = 0;
        end
    endtask

    task automatic cmp_one(input int i, input logic signed [NB-1:0] smp,
                           input logic signed [NB-1:0] sym, input logic [1:0] gray,
                           input logic val);
        check($sformatf("sample_os%0d", osv[i]), int'(smp), m_smp[i]);
        check($sformatf("symbol_os%0d", osv[i]), int'(sym), m_sym[i]);
        check($sformatf("gray_os%0d", osv[i]), int'(gray), m_gray[i]);
        check($sformatf("valid_os%0d", osv[i]), int'(val), m_val[i]);
    endtask

    task automatic cmp_all();
        cmp_one(0, smp_a, sym_a, gray_a, val_a);
        cmp_one(1, smp_b, sym_b, gray_b, val_b);
    endtask

    // One clock cycle: apply inputs, check strobes/async reset, clock, check outputs.
    task automatic cyc(input bit e, input bit p, input logic [1:0] b, input bit r);
        logic [1:0] sb;
        en = e; prbs = p; bits = b; rst_n = r;
        #1;
        if (!r) begin
            model_reset();
            cmp_all();
        end
        s_req = req_a;
        check("req_os4", int'(req_a), int'(e && m_ph[0] == 0 && !p));
        check("req_os1", int'(req_b), int'(e && m_ph[1] == 0 && !p));
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                if (e) begin
                    if (m_ph[i] == 0) begin
                        if (p) begin
                            sb = {h[m_ptr[i] + 9], h[m_ptr[i] + 10]};
                            m_ptr[i] += 2;
                        end else begin
                            sb = b;
                        end
                        m_smp[i] = lvl(sb); m_sym[i] = lvl(sb);
                        m_gray[i] = int'(sb); m_val[i] = 1;
                    end else begin
                        m_smp[i] = 0; m_val[i] = 0;
                    end
                    m_ph[i] = (m_ph[i] + 1) % osv[i];
                end else begin
                    m_val[i] = 0;
                end
            end
        end
        cmp_all();
        if (val_a === 1'b1) q_sym.push_back(int'(sym_a));
    endtask

    task automatic check_q(input string nm, input int k, input int exp);
        check(nm, (k < q_sym.size()) ? q_sym[k] : 9999, exp);
    endtask

    initial begin
        logic [1:0] pat [4];
        int idx;
        bit f;
        bit rp;
        int exp_req [3];

        osv[0] = 4; osv[1] = 1;
        for (int k = 0; k < 9; k++) h[k] = 1'b1;
        for (int k = 0; k < NPB; k++) h[k + 9] = h[k] ^ h[k + 4];
        pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b10;
        exp_req[0] = 0; exp_req[1] = 0; exp_req[2] = 1;
        model_reset();
        en = 1'b0; prbs = 1'b0; bits = 2'b00; rst_n = 1'b0;

        // Reset state
        cyc(0, 0, 2'b00, 0);
        cyc(0, 0, 2'b00, 0);
        check("reset_sample", int'(smp_a), 0);
        check("reset_valid", int'(val_a), 0);

        // External mode, Gray pattern 00/01/11/10
        q_sym.delete();
        idx = 0;
        for (int k = 0; k < 16; k++) begin
            f = (m_ph[0] == 0);
            cyc(1, 0, pat[idx % 4], 1);
            if (f) idx++;
        end
        check("ext_valid_count", q_sym.size(), 4);
        check_q("ext_sym0", 0, -96);
        check_q("ext_sym1", 1, -32);
        check_q("ext_sym2", 2, 32);
        check_q("ext_sym3", 3, 96);

        // PRBS mode from reset: 00, 00, 01
        cyc(0, 1, 2'b00, 0);
        q_sym.delete();
        for (int k = 0; k < 12; k++) cyc(1, 1, 2'b00, 1);
        check_q("prbs_sym0", 0, -96);
        check_q("prbs_sym1", 1, -96);
        check_q("prbs_sym2", 2, -32);

        // OS=1 alternating 10/00, no zero insertion
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, (k % 2 == 0) ? 2'b10 : 2'b00, 1);
            check("os1_alt_sample", int'(smp_b), (k % 2 == 0) ? 96 : -96);
        end

        // Enable dropped at phase 2 for 5 cycles, fetch 2 enabled cycles after resume
        for (int k = 0; k < 8 && m_ph[0] != 2; k++) cyc(1, 0, 2'b11, 1);
        check("freeze_phase_reached", m_ph[0], 2);
        for (int k = 0; k < 5; k++) cyc(0, 0, 2'b01, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 2'b01, 1);
            check("resume_req", int'(s_req), exp_req[k]);
        end

        // Async reset at phase 1 in PRBS mode, then sequence restarts
        for (int k = 0; k < 8 && m_ph[0] != 1; k++) cyc(1, 1, 2'b00, 1);
        cyc(1, 1, 2'b00, 0);
        check("async_rst_symbol", int'(sym_a), 0);
        q_sym.delete();
        for (int k = 0; k < 12; k++) cyc(1, 1, 2'b00, 1);
        check_q("rst_prbs_sym0", 0, -96);
        check_q("rst_prbs_sym1", 1, -96);
        check_q("rst_prbs_sym2", 2, -32);

        // Source switch at phase 2 takes effect at the next phase 0
        for (int k = 0; k < 8 && m_ph[0] != 2; k++) cyc(1, 0, 2'b11, 1);
        for (int k = 0; k < 8; k++) cyc(1, 1, 2'b10, 1);
        for (int k = 0; k < 8; k++) cyc(1, 0, 2'b10, 1);

        // Randomized traffic
        rp = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(39) == 0) rp = ~rp;
            cyc(($urandom_range(7) != 0), rp, 2'($urandom()), ($urandom_range(399) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pam4_tx_mapper.md
Name: pam4_tx_mapper

Overview:
- Transmit-side PAM4 symbol mapper. It is the inverse of the receive slicer.
- Takes 2-bit symbols from upstream, or from an internal PRBS9 source for link/BER tests.
- Gray-maps each symbol to a signed fixed-point PAM4 level and zero-stuffs it to OS samples per symbol, producing the stream that drives the TX shaping filter.
- Generates its own symbol-rate request strobe toward the bit source.

Parameters:
- NB, 8, total sample width (signed, two's complement).
- NBF, 7, fractional bits of the sample. Requires NBF >= 2 and NB >= NBF+1.
- OS, 4, oversampling factor (samples per symbol). Requires OS >= 1.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous active-low reset
- i_enable  in  1  global enable. Low freezes all state.
- i_prbs_en  in  1  1 = internal PRBS9 source, 0 = external i_bits
- i_bits  in  2  external symbol bits {MSB,LSB}. Sampled when o_req=1.
- o_req  out  1  symbol request. High on phase 0 while enabled and i_prbs_en=0.
- o_sample  out  NB  zero-stuffed oversampled PAM4 sample (signed)
- o_symbol  out  NB  last mapped level, held between symbols (signed)
- o_gray_level  out  2  bits of the last mapped symbol
- o_sym_valid  out  1  1-cycle pulse when o_symbol/o_gray_level update

Behaviour:
- Reset (async, i_reset=0):
  - phase counter = 0; PRBS state = 9'h1FF.
  - o_sample, o_symbol, o_gray_level, o_sym_valid = 0.
  - Reset mid-symbol aborts the symbol with no partial output.
- Phase counter:
  - ceil(log2(OS)) bits, minimum 1.
  - Advances 0..OS-1 and wraps, one step per cycle with i_enable=1.
  - Holds when i_enable=0. With OS=1 every enabled cycle is phase 0.
- Symbol fetch, on an enabled cycle at phase 0:
  - i_prbs_en=1: bits come from PRBS9; o_req=0.
  - i_prbs_en=0: bits are i_bits; o_req=1.
  - i_prbs_en is sampled only at phase 0. A change mid-symbol takes effect on the next symbol.
- PRBS9:
  - Polynomial x^9+x^5+1, state s[8:0], stepped twice per PRBS symbol.
  - Step: n = s[8]^s[4]; s <= {s[7:0], n}; emitted bit = n.
  - First emitted bit is MSB, second is LSB.
  - State advances only on PRBS fetches. It holds in external mode and when disabled.
- Gray map, bits -> level:
  - 00 -> -(3<<(NBF-2)) = -0.75
  - 01 -> -(1<<(NBF-2)) = -0.25
  - 11 -> +(1<<(NBF-2)) = +0.25
  - 10 -> +(3<<(NBF-2)) = +0.75
  - This is the exact inverse of the receive slicer decision levels.
- Output timing: all outputs registered, latency 1 cycle from the phase-0 fetch.
  - Cycle after fetch: o_sample = level, o_symbol = level, o_gray_level = bits, o_sym_valid = 1.
  - Cycles after enabled phases 1..OS-1: o_sample = 0, o_sym_valid = 0; o_symbol and o_gray_level hold.
- i_enable=0:
  - o_sample and o_symbol hold their last values.
  - o_sym_valid and o_req are forced 0.
  - Resume continues from the frozen phase.

Decomposition:
- Shared pam4_pkg: Gray code constants GRAY_00/01/11/10, and the level constants LVL_NEG_075/NEG_025/POS_025/POS_075 as functions of NB/NBF. The receive slicer uses the same package.
- One natural sub-module: prbs9_gen (enable, step-by-2, 2-bit output, seed parameter), reusable by an RX BER checker.

Test Plan:
- NB=8, NBF=7, OS=4, external mode, i_bits = 00, 01, 11, 10 on successive o_req:
  - o_symbol = -96, -32, +32, +96 (0xA0, 0xE0, 0x20, 0x60).
  - o_sample = level, 0, 0, 0 per symbol.
  - o_sym_valid pulses once every 4 cycles.
- PRBS mode from reset, OS=4: first three symbols are gray 00, 00, 01 → o_symbol -96, -96, -32; o_req stays 0.
- OS=1, external mode, alternating 10/00:
  - o_req high every enabled cycle.
  - o_sample toggles +96/-96 each cycle with 1-cycle latency; no zeros inserted.
- i_enable dropped at phase 2 for 5 cycles:
  - o_sym_valid=0, o_req=0, outputs and phase held.
  - The next symbol fetch occurs 2 enabled cycles after resume.
- Assert i_reset=0 at phase 1 in PRBS mode:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the sequence restarts at 00, 00, 01.
- Toggle i_prbs_en at phase 2: the current symbol completes unchanged, and the new source is used at the next phase 0.
